// File: rtl/multi_channel_pio.sv
// Multi-channel PIO: per-channel DATA/IN/MASK/EDGE registers, two-flop input sync, edge capture and level irq.
// Reads are combinational; DATA reaches out_port one cycle after the write; the slave never stalls.
module multi_channel_pio #(
  parameter int               WIDTH       = 8,
  parameter int               NUM_CH      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0,
  localparam int              CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CH_BITS+2:0]      address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic [NUM_CH*WIDTH-1:0] in_port,
  output logic [NUM_CH*WIDTH-1:0] out_port,
  output logic                    irq
);

  localparam int AW = CH_BITS + 3;
  localparam int TW = NUM_CH * WIDTH;

  logic [TW-1:0]    data_q, mask_q, edge_q;
  logic [TW-1:0]    s1_q, s2_q, s3_q;
  logic [TW-1:0]    data_d, mask_d, edge_d, det;
  logic [1:0]       settle_q;
  logic             det_en;
  logic             irq_q;
  logic [AW-1:0]    ch_sel;
  logic [2:0]       reg_sel;
  logic             wr_en;
  logic [WIDTH-1:0] wd;

  assign ch_sel  = address >> 3;
  assign reg_sel = address[2:0];
  assign wr_en   = chipselect & ~write_n;
  assign wd      = writedata[WIDTH-1:0];
  assign det_en  = (settle_q == 2'd3);

  generate
    if (WIDTH < 32) begin : g_unused_wd
      logic unused_wd_hi;
      assign unused_wd_hi = &{1'b0, writedata[31:WIDTH]};
    end
  endgenerate

  // Sync flops come out of reset at 0, so detection waits for the pipeline to fill
  always_comb begin
    det = '0;
    if (det_en) begin
      if (EDGE_TYPE == 0)      det = s2_q & ~s3_q;
      else if (EDGE_TYPE == 1) det = ~s2_q & s3_q;
      else                     det = s2_q ^ s3_q;
    end
  end

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    edge_d = edge_q | det;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en && (ch_sel == AW'(c))) begin
        case (reg_sel)
          3'd0: data_d[c*WIDTH +: WIDTH] = wd;
          3'd2: mask_d[c*WIDTH +: WIDTH] = wd;
          // a fresh detection on the same bit beats the clear
          3'd3: edge_d[c*WIDTH +: WIDTH] = (edge_q[c*WIDTH +: WIDTH] & ~wd) | det[c*WIDTH +: WIDTH];
          3'd4: data_d[c*WIDTH +: WIDTH] = data_q[c*WIDTH +: WIDTH] | wd;
          3'd5: data_d[c*WIDTH +: WIDTH] = data_q[c*WIDTH +: WIDTH] & ~wd;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == AW'(c)) begin
        case (reg_sel)
          3'd0: readdata[WIDTH-1:0] = data_q[c*WIDTH +: WIDTH];
          3'd1: readdata[WIDTH-1:0] = s2_q[c*WIDTH +: WIDTH];
          3'd2: readdata[WIDTH-1:0] = mask_q[c*WIDTH +: WIDTH];
          3'd3: readdata[WIDTH-1:0] = edge_q[c*WIDTH +: WIDTH];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= {NUM_CH{RESET_VALUE}};
      mask_q   <= '0;
      edge_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      settle_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      s1_q     <= in_port;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      irq_q    <= |(edge_q & mask_q);
    end
  end

  assign out_port = data_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_multi_channel_pio.sv
// Scoreboard bench for multi_channel_pio (WIDTH=8, NUM_CH=2, RESET_VALUE=0x5A, rising-edge capture).
module tb_multi_channel_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic        irq;

  always #5 clk = ~clk;

  multi_channel_pio #(
    .WIDTH(8), .NUM_CH(2), .RESET_VALUE(8'h5A), .EDGE_TYPE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [7:0]  md [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow: got 0x%08h with no expected entry", got);
    end else begin
      check_val(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int off, input logic [31:0] wd);
    logic [7:0] b;
    b = wd[7:0];
    case (off)
      0: md[ch] = b;
      4: md[ch] = md[ch] | b;
      5: md[ch] = md[ch] & ~b;
      default: ;
    endcase
    sb_push($sformatf("out_port_after_wr_ch%0d_off%0d", ch, off), {16'h0, md[1], md[0]});
    @(negedge clk);
    address    = 4'(ch * 8 + off);
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = wd;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    sb_pop({16'h0, out_port});
  endtask

  task automatic rd(input string tag, input int ch, input int off, input logic [31:0] exp);
    sb_push(tag, exp);
    address = 4'(ch * 8 + off);
    #1;
    sb_pop(readdata);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    sb_push(tag, 32'(e));
    sb_pop(32'(irq));
  endtask

  task automatic chk_out(input string tag);
    sb_push(tag, {16'h0, md[1], md[0]});
    sb_pop({16'h0, out_port});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    in_port    = 16'hFFFF;
    md[0]      = 8'h5A;
    md[1]      = 8'h5A;

    // reset state, inputs held high through release
    #12;
    chk_out("out_port_in_reset");
    chk_irq("irq_in_reset", 1'b0);
    rd("in_ch0_in_reset", 0, 1, 32'h0);
    rd("edge_ch0_in_reset", 0, 3, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_irq("irq_settle", 1'b0);
    end
    rd("edge_ch0_settle", 0, 3, 32'h0);
    rd("edge_ch1_settle", 1, 3, 32'h0);
    rd("in_ch0_ones", 0, 1, 32'hFF);
    @(negedge clk);
    in_port = 16'h0000;
    repeat (4) step();
    rd("edge_ch0_falling_ignored", 0, 3, 32'h0);
    rd("in_ch0_zero", 0, 1, 32'h0);

    // DATA / SET / CLR on channel 1
    wr(1, 0, 32'hA5);
    check_val("ch1_data_a5", 32'(out_port[15:8]), 32'hA5);
    wr(1, 4, 32'h0F);
    check_val("ch1_set_af", 32'(out_port[15:8]), 32'hAF);
    wr(1, 5, 32'h81);
    check_val("ch1_clr_2e", 32'(out_port[15:8]), 32'h2E);
    check_val("ch0_unchanged", 32'(out_port[7:0]), 32'h5A);
    rd("data_ch1_rb", 1, 0, 32'h2E);
    rd("set_ch1_reads0", 1, 4, 32'h0);
    rd("clr_ch1_reads0", 1, 5, 32'h0);

    // rising-edge capture timing and irq
    wr(0, 2, 32'h01);
    rd("mask_ch0_rb", 0, 2, 32'h01);
    @(negedge clk);
    in_port[0] = 1'b1;
    step();
    rd("in_ch0_k", 0, 1, 32'h0);
    rd("edge_ch0_k", 0, 3, 32'h0);
    step();
    rd("in_ch0_k1", 0, 1, 32'h01);
    rd("edge_ch0_k1", 0, 3, 32'h0);
    step();
    rd("edge_ch0_k2", 0, 3, 32'h01);
    chk_irq("irq_k2", 1'b0);
    step();
    chk_irq("irq_k3", 1'b1);
    wr(0, 3, 32'h00);
    rd("edge_w0_no_effect", 0, 3, 32'h01);
    wr(0, 3, 32'h01);
    rd("edge_w1c", 0, 3, 32'h0);
    chk_irq("irq_lags_clear", 1'b1);
    step();
    chk_irq("irq_cleared", 1'b0);

    // clear colliding with a new detection
    @(negedge clk);
    in_port[0] = 1'b0;
    repeat (3) step();
    rd("edge_ch0_fall", 0, 3, 32'h0);
    @(negedge clk);
    in_port[0] = 1'b1;
    step();
    step();
    rd("edge_ch0_before_collide", 0, 3, 32'h0);
    wr(0, 3, 32'h01);
    rd("edge_set_wins", 0, 3, 32'h01);
    wr(0, 3, 32'h01);
    rd("edge_cleared_after_collide", 0, 3, 32'h0);
    step();

    // mask gating and OR across channels
    @(negedge clk);
    in_port[15] = 1'b1;
    repeat (3) step();
    rd("edge_ch1_bit7", 1, 3, 32'h80);
    chk_irq("irq_masked", 1'b0);
    wr(1, 2, 32'h80);
    chk_irq("irq_mask_lag", 1'b0);
    step();
    chk_irq("irq_ch1", 1'b1);
    wr(1, 3, 32'h80);
    step();
    chk_irq("irq_ch1_cleared", 1'b0);
    rd("edge_ch1_cleared", 1, 3, 32'h0);

    // unmapped offsets
    for (int ch = 0; ch < 2; ch++) begin
      for (int off = 4; off < 8; off++) begin
        rd($sformatf("unmapped_ch%0d_off%0d", ch, off), ch, off, 32'h0);
      end
    end
    wr(0, 6, 32'hFF);
    wr(1, 7, 32'hFF);
    rd("mask_ch0_after_unmapped", 0, 2, 32'h01);
    rd("mask_ch1_after_unmapped", 1, 2, 32'h80);
    rd("edge_ch0_after_unmapped", 0, 3, 32'h0);

    // upper writedata bits ignored, then reset mid-capture
    wr(0, 0, 32'hFFFFFF3C);
    rd("data_ch0_3c", 0, 0, 32'h3C);
    wr(0, 2, 32'h02);
    @(negedge clk);
    in_port[1] = 1'b1;
    repeat (4) step();
    chk_irq("irq_before_reset", 1'b1);
    @(negedge clk);
    in_port[2] = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    md[0] = 8'h5A;
    md[1] = 8'h5A;
    chk_out("out_port_async_reset");
    chk_irq("irq_async_reset", 1'b0);
    rd("edge_ch0_in_reset2", 0, 3, 32'h0);
    rd("mask_ch0_in_reset2", 0, 2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) step();
    rd("edge_ch0_after_reset2", 0, 3, 32'h0);
    rd("edge_ch1_after_reset2", 1, 3, 32'h0);
    chk_irq("irq_after_reset2", 1'b0);
    chk_out("out_port_after_reset2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
